// File: rtl/result_streamer.sv
// result_streamer
//   Drains a contiguous block of rows from the result BRAM and presents them
//   as an AXI-Stream style sequence of beats, one row per beat.
//
//   Ports
//     clk, rstn         single clock, synchronous active-low reset
//     start             job-complete pulse; sampled only while idle
//     base_addr, length first row and row count of the block (length 0..2^ADDR_WIDTH)
//     rd_en, rd_addr    result-BRAM read port (data returns one cycle later)
//     rd_dout           result-BRAM read data
//     m_tdata, m_tvalid, m_tready, m_tlast   output stream
//     busy              high while reading or draining a job
//     done              one-cycle pulse when the job has fully drained
module result_streamer #(
  parameter int PE_COUNT   = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                                 clk,
  input  logic                                 rstn,
  input  logic                                 start,
  input  logic [ADDR_WIDTH-1:0]                base_addr,
  input  logic [ADDR_WIDTH:0]                  length,
  output logic                                 rd_en,
  output logic [ADDR_WIDTH-1:0]                rd_addr,
  input  logic [PE_COUNT-1:0][DATA_WIDTH-1:0]  rd_dout,
  output logic [PE_COUNT-1:0][DATA_WIDTH-1:0]  m_tdata,
  output logic                                 m_tvalid,
  input  logic                                 m_tready,
  output logic                                 m_tlast,
  output logic                                 busy,
  output logic                                 done
);

  localparam int FIFO_DEPTH = 3;
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, READ, DRAIN, FINISH} state_t;

  state_t                             state, state_nxt;
  logic [ADDR_WIDTH:0]                len_q;
  logic [ADDR_WIDTH:0]                rd_cnt;
  logic [ADDR_WIDTH-1:0]              rd_addr_q;
  logic                               vld_p1;
  logic                               last_p1;
  logic [PE_COUNT-1:0][DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];
  logic                               fifo_last [FIFO_DEPTH];
  logic [1:0]                         wr_ptr, rd_ptr, count;
  logic [2:0]                         pending;
  logic                               last_rd, push, pop;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Credit check uses stored rows plus the read still returning, never
  // m_tready, so a free slot is guaranteed before every read is issued.
  assign pending = {1'b0, count} + {2'b00, vld_p1};
  assign rd_en   = (state == READ) && (pending < 3'd3);
  assign rd_addr = rd_addr_q;
  assign last_rd = (rd_cnt == len_q - CNT_ONE);

  assign push     = vld_p1;
  assign m_tvalid = (count != 2'd0);
  assign pop      = m_tvalid && m_tready;
  // Gate the head with valid so the idle bus reads zero without resetting storage.
  assign m_tdata  = m_tvalid ? fifo_data[rd_ptr] : '0;
  assign m_tlast  = m_tvalid && fifo_last[rd_ptr];

  assign busy = (state == READ) || (state == DRAIN);
  assign done = (state == FINISH);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (length == '0) ? FINISH : READ;
      READ:    if (rd_en && last_rd) state_nxt = DRAIN;
      DRAIN:   if (pop && m_tlast) state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p0 -> p1: read issue, address/count bookkeeping, FIFO control
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= IDLE;
      len_q     <= '0;
      rd_cnt    <= '0;
      rd_addr_q <= '0;
      vld_p1    <= 1'b0;
      last_p1   <= 1'b0;
      wr_ptr    <= 2'd0;
      rd_ptr    <= 2'd0;
      count     <= 2'd0;
    end else begin
      state   <= state_nxt;
      vld_p1  <= rd_en;
      last_p1 <= rd_en && last_rd;
      if (state == IDLE && start) begin
        len_q     <= length;
        rd_addr_q <= base_addr;
        rd_cnt    <= '0;
      end else if (rd_en) begin
        rd_addr_q <= rd_addr_q + ADDR_ONE;
        rd_cnt    <= rd_cnt + CNT_ONE;
      end
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Stage p1 -> FIFO: capture returning BRAM row alongside its last-beat tag
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= rd_dout;
      fifo_last[wr_ptr] <= last_p1;
    end
  end

endmodule

// File: tb/tb_result_streamer.sv
module tb_result_streamer;
  localparam int PE = 4;
  localparam int DW = 32;
  localparam int AW = 10;
  localparam int LW = AW + 1;
  localparam int W  = PE * DW;

  logic                   clk = 1'b0;
  logic                   rstn = 1'b0;
  logic                   start = 1'b0;
  logic [AW-1:0]          base_addr = '0;
  logic [AW:0]            length = '0;
  logic                   rd_en;
  logic [AW-1:0]          rd_addr;
  logic [PE-1:0][DW-1:0]  rd_dout = '0;
  logic [PE-1:0][DW-1:0]  m_tdata;
  logic                   m_tvalid;
  logic                   m_tready = 1'b1;
  logic                   m_tlast;
  logic                   busy;
  logic                   done;

  result_streamer #(.PE_COUNT(PE), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rstn(rstn), .start(start), .base_addr(base_addr), .length(length),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_dout(rd_dout),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference row contents: every lane is distinct and encodes its address.
  function automatic logic [W-1:0] row_data(input logic [AW-1:0] a);
    logic [W-1:0] r;
    for (int j = 0; j < PE; j++)
      r[j*DW +: DW] = (DW'(j + 1) << 24) | 32'h00A5_0000 | DW'(a);
    return r;
  endfunction

  // Behavioural result BRAM: one-cycle read latency.
  always @(posedge clk) if (rd_en) rd_dout <= row_data(rd_addr);

  int passed = 0, total = 0;
  logic [AW-1:0] exp_addr_q[$];
  logic [W:0]    exp_beat_q[$];
  int issued = 0, popped = 0, beats = 0, done_cnt = 0;
  int first_rd = -1, first_vld = -1, last_cyc = -1, done_cyc = -1;
  int t0 = 0, d0 = 0, b0 = 0;
  bit busy_seen = 0;
  int rdy_mode = 0;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic note_fail(input string nm);
    total++;
    $display("FAIL %s", nm);
  endtask

  // Ready driver
  initial forever begin
    @(posedge clk); #1;
    case (rdy_mode)
      0:       m_tready = 1'b1;
      1:       m_tready = ~m_tready;
      default: m_tready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor / scoreboard
  logic          prev_vld = 0, prev_rdy = 0, prev_last = 0, prev_rstn = 0;
  logic [W-1:0]  prev_data = '0;
  initial forever begin
    logic [W:0] e;
    @(negedge clk);
    if (busy) busy_seen = 1;
    if (rd_en) begin
      if (exp_addr_q.size() == 0) note_fail($sformatf("unexpected_rd_en addr=%0d", rd_addr));
      else chk("rd_addr", W'(rd_addr), W'(exp_addr_q.pop_front()));
      chk("rd_credit", W'(issued - popped < 3), W'(1));
      issued++;
      if (first_rd < 0) first_rd = cyc;
    end
    if (m_tvalid) begin
      if (first_vld < 0) first_vld = cyc;
      if (prev_vld && !prev_rdy && prev_rstn) begin
        chk("stall_data", m_tdata, prev_data);
        chk("stall_last", W'(m_tlast), W'(prev_last));
      end
    end
    if (m_tvalid && m_tready) begin
      if (exp_beat_q.size() == 0) note_fail($sformatf("unexpected_beat data=%0h", m_tdata));
      else begin
        e = exp_beat_q.pop_front();
        chk("beat_data", m_tdata, e[W-1:0]);
        chk("beat_last", W'(m_tlast), W'(e[W]));
      end
      popped++;
      beats++;
      if (m_tlast) last_cyc = cyc;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    prev_vld = m_tvalid; prev_rdy = m_tready; prev_last = m_tlast;
    prev_data = m_tdata; prev_rstn = rstn;
  end

  task automatic start_job(input int b, input int n);
    logic [AW-1:0] a;
    @(posedge clk); #1;
    base_addr = AW'(b); length = LW'(n); start = 1'b1;
    for (int i = 0; i < n; i++) begin
      a = AW'(b + i);
      exp_addr_q.push_back(a);
      exp_beat_q.push_back({(i == n - 1), row_data(a)});
    end
    first_rd = -1; first_vld = -1; last_cyc = -1; done_cyc = -1;
    busy_seen = 0; t0 = cyc; d0 = done_cnt; b0 = beats;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic pulse_start(input int b, input int n);
    @(posedge clk); #1;
    base_addr = AW'(b); length = LW'(n); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int budget);
    int k = 0;
    while (done_cnt == d0 && k < budget) begin
      @(negedge clk); #1;
      k++;
    end
    if (done_cnt == d0) note_fail($sformatf("%s done_timeout", nm));
    repeat (2) @(negedge clk);
    #1;
    chk({nm, "_done_pulses"}, W'(done_cnt - d0), W'(1));
    chk({nm, "_beats_left"}, W'(exp_beat_q.size()), W'(0));
    chk({nm, "_reads_left"}, W'(exp_addr_q.size()), W'(0));
  endtask

  initial begin
    int k;
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rd_en",  W'(rd_en), W'(0));
    chk("rst_rd_addr", W'(rd_addr), W'(0));
    chk("rst_tvalid", W'(m_tvalid), W'(0));
    chk("rst_tlast",  W'(m_tlast), W'(0));
    chk("rst_tdata",  m_tdata, W'(0));
    chk("rst_busy",   W'(busy), W'(0));
    chk("rst_done",   W'(done), W'(0));
    @(posedge clk); #1 rstn = 1'b1;

    // Basic job with exact latencies
    rdy_mode = 0;
    start_job(0, 4);
    wait_done("basic", 50);
    chk("lat_first_rd",   W'(first_rd - t0),  W'(1));
    chk("lat_first_vld",  W'(first_vld - t0), W'(3));
    chk("lat_last_beat",  W'(last_cyc - t0),  W'(6));
    chk("lat_done",       W'(done_cyc - t0),  W'(7));
    chk("basic_beats",    W'(beats - b0),     W'(4));

    // Toggling ready, stalls
    rdy_mode = 1;
    start_job(5, 8);
    wait_done("toggle", 100);
    chk("toggle_beats", W'(beats - b0), W'(8));

    // Address wrap
    rdy_mode = 0;
    start_job(1022, 4);
    wait_done("wrap", 50);
    chk("wrap_beats", W'(beats - b0), W'(4));

    // Zero length
    start_job(7, 0);
    wait_done("zero", 20);
    chk("zero_done_cyc", W'(done_cyc - t0), W'(1));
    chk("zero_no_rd",    W'(first_rd), W'(-1));
    chk("zero_no_vld",   W'(first_vld), W'(-1));
    chk("zero_busy",     W'(busy_seen), W'(0));

    // Single row
    start_job(50, 1);
    wait_done("single", 30);
    chk("single_beats", W'(beats - b0), W'(1));

    // Start pulsed mid-job is ignored
    start_job(100, 6);
    repeat (2) @(posedge clk);
    pulse_start(300, 3);
    wait_done("restart_ignored", 60);
    chk("ignored_beats", W'(beats - b0), W'(6));

    // Reset after the second beat abandons the job
    start_job(200, 6);
    k = 0;
    while (beats - b0 < 2 && k < 50) begin
      @(negedge clk); #1;
      k++;
    end
    if (beats - b0 < 2) note_fail("abort_wait_beats timeout");
    @(posedge clk); #1 rstn = 1'b0;
    @(posedge clk); #1;
    exp_addr_q.delete(); exp_beat_q.delete();
    issued = 0; popped = 0;
    @(negedge clk);
    chk("abort_tvalid", W'(m_tvalid), W'(0));
    chk("abort_busy",   W'(busy), W'(0));
    chk("abort_rd_en",  W'(rd_en), W'(0));
    @(posedge clk); #1 rstn = 1'b1;
    repeat (3) @(posedge clk);
    start_job(0, 2);
    wait_done("after_reset", 30);
    chk("after_reset_beats", W'(beats - b0), W'(2));

    // Randomised jobs with random backpressure
    rdy_mode = 2;
    for (int j = 0; j < 10; j++) begin
      int n;
      n = int'($urandom_range(1, 12));
      start_job(int'($urandom_range(0, (1 << AW) - 1)), n);
      wait_done($sformatf("rand%0d", j), 400);
      chk($sformatf("rand%0d_beats", j), W'(beats - b0), W'(n));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
